zig_zag_pp: RTL and testbench
=============================

# zig_zag_pp

Parametrised ping-pong zig-zag reorderer between the DCT/quantiser and the entropy coder. It accepts 64-coefficient 8x8 blocks on an AXI4-Stream slave and emits them reordered on an AXI4-Stream master. The default direction is raster to zig-zag; a per-block inverse mode does zig-zag to raster. Two 64-entry banks give full throughput of one coefficient per cycle with no inter-block bubble.

## Interface
- DATA_WIDTH, 12: coefficient width (signed); uses bits [DATA_WIDTH-1:0] of input tdata.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- inverse_i  in  1  mode select; sampled on the first accepted beat of each block; 1 = zig-zag-to-raster.
- dct_i  axi4_stream_if.slave  tdata>=DATA_WIDTH  coefficient input, 64 beats per block.
- zz_o  axi4_stream_if.master  tdata>=DATA_WIDTH  reordered output, sign-extended to tdata width, tstrb/tkeep all ones.
- last_nz_o  out  7  only with ZZ_LAST_NZ_EN; count of coefficients up to and including the last nonzero one, zig-zag order, for the bank being drained.

## Operation
- Per-bank state: data[64], full flag, inv, user, last, and (optional) last_nz. Pointers wr_bank, rd_bank; counters wr_cnt[5:0], rd_cnt[5:0].
- Bank states: EMPTY -> FILLING (first beat accepted) -> FULL (64th beat accepted) -> DRAINING (first output beat) -> EMPTY (64th output beat accepted).
- dct_i.tready = !full[wr_bank]. zz_o.tvalid = full[rd_bank].
- Write address: forward = wr_cnt; inverse = zz2raster[wr_cnt]. Read address: forward = zz2raster[rd_cnt]; inverse = rd_cnt.
- On wr_cnt==63 accept: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0. On rd_cnt==63 handshake: clear full[rd_bank], toggle rd_bank, rd_cnt wraps.
- tuser: OR of all tuser beats in the block, stored per bank, output only on rd_cnt==0.
- tlast: OR of all tlast beats in the block, output only on rd_cnt==63.
- Same-cycle fill-complete of one bank and drain-complete of the other: both flags update, no bubble on either side.
- The full-set and full-clear for the same bank never coincide, because a bank cannot fill while it drains.

## Timing
- Reset values: zz_o.tvalid 0, tdata 0, tuser 0, tlast 0, last_nz_o 0, both banks EMPTY, counters 0, pointers 0. dct_i.tready is 1 after reset (0 while rst_i is asserted).
- Latency: the 64th input beat is accepted at edge t; zz_o.tvalid is high from t+1 with coefficient zz index 0.
- Sustained throughput is 1 beat/cycle with zz_o.tready held high.
- Backpressure: with zz_o.tready low, 128 input beats are accepted, then dct_i.tready drops. dct_i.tready rises the cycle after a bank completes draining.
- tdata is combinational from bank memory and stays stable while tvalid && !tready.
- Reset mid-block discards any partial or full banks; no output beat follows reset until a new 64-beat block completes.

## Configuration
- ZZ_LAST_NZ_EN defined: the last_nz_o port exists.
  - On each accepted nonzero beat, the bank's last_nz becomes max(last_nz, zz_index+1).
  - zz_index is raster2zz[wr_cnt] in forward mode and wr_cnt in inverse mode.
  - The value resets to 0 at block start.
  - last_nz_o is valid whenever zz_o.tvalid; 0 means an all-zero block.
- ZZ_LAST_NZ_EN undefined: no port, no tracking logic.

## Structure
- Package zz_pkg holds:
  - coef_t (logic signed [DATA_WIDTH-1:0]);
  - localparam arrays ZZ2RASTER[64] and RASTER2ZZ[64] (6-bit);
  - localparam BLK_SIZE = 64.
- Sub-module zz_bank: one 64xDATA_WIDTH array with one write port and one asynchronous read port, plus flag registers. It is instantiated twice.

## Test plan
- Forward ramp: raster beats 0..63, inverse_i=0 -> output 0,1,8,16,9,2,3,10,17,24,... ending 55,62,63.
- Inverse: feed the forward output sequence with inverse_i=1 -> output 0..63 in order. Mixed mode across consecutive blocks is honoured per block.
- Streaming: 3 back-to-back blocks with zz_o.tready=1 -> 192 output beats in 192 consecutive cycles starting at t+1; dct_i.tready never low.
- Backpressure: zz_o.tready=0 -> exactly 128 beats accepted, then tready=0. Release -> data is intact and in order.
- Sideband: tuser on input beat 5, tlast on beat 63 -> tuser only on output beat 0, tlast only on output beat 63. With ZZ_LAST_NZ_EN, only raster 0 and 9 nonzero -> last_nz_o=5; an all-zero block -> 0.
- Reset asserted after 30 beats of a block -> tvalid 0 immediately. The next full block outputs correctly, with no stale data.

Source files
------------

// File: rtl/zz_pkg.sv
// zz_pkg: shared types and lookup tables for the zig-zag ping-pong reorderer.
//   COEF_W       default coefficient width
//   BLK_SIZE     coefficients per 8x8 block
//   coef_t       signed coefficient type
//   bank_state_e per-bank lifecycle state
//   ZZ2RASTER    zig-zag index -> raster index
//   RASTER2ZZ    raster index -> zig-zag index
package zz_pkg;

  localparam int COEF_W   = 12;
  localparam int BLK_SIZE = 64;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  localparam logic [5:0] ZZ2RASTER [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [5:0] RASTER2ZZ [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: minimal AXI4-Stream bundle.
//   TDATA_W  data width; tstrb/tkeep carry one bit per byte
//   master   drives tvalid/tdata/tstrb/tkeep/tlast/tuser, receives tready
//   slave    the mirror image
interface axi4_stream_if #(
  parameter int TDATA_W = 16
) ();
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_W-1:0]         tdata;
  logic [(TDATA_W+7)/8-1:0]   tstrb;
  logic [(TDATA_W+7)/8-1:0]   tkeep;
  logic                       tlast;
  logic                       tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/zz_bank.sv
// zz_bank: one 64-entry coefficient bank of the ping-pong pair.
// One synchronous write port, one asynchronous read port, plus the bank's
// lifecycle state and per-block sideband (mode, tuser, tlast, last_nz).
// Optional: ZZ_LAST_NZ_EN adds zz_idx_i / last_nz_o and the tracking logic.
//   clk_i, rst_i        clock, async active-high reset
//   wr_en_i, first_i    beat accepted into this bank; it is beat 0 of a block
//   fill_done_i         the accepted beat is beat 63
//   inv_i, user_i, last_i  mode and sideband of the accepted beat
//   wr_addr_i, wr_data_i   storage address and coefficient
//   rd_addr_i, rd_data_o   combinational read
//   rd_first_i          first output beat of this bank handshaken
//   drain_done_i        last output beat of this bank handshaken
//   full_o, inv_o, user_o, last_o  bank status and block sideband
//
// state         | meaning
// BANK_EMPTY    | no data, waiting for beat 0 of a block
// BANK_FILLING  | beats 1..63 of a block being written
// BANK_FULL     | complete block, no output beat taken yet
// BANK_DRAINING | output beats being taken, bank still owned by reader
module zz_bank
  import zz_pkg::*;
#(
  parameter int DATA_WIDTH = COEF_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  first_i,
  input  logic                  fill_done_i,
  input  logic                  inv_i,
  input  logic                  user_i,
  input  logic                  last_i,
  input  logic [5:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
`ifdef ZZ_LAST_NZ_EN
  input  logic [5:0]            zz_idx_i,
  output logic [6:0]            last_nz_o,
`endif
  input  logic [5:0]            rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_first_i,
  input  logic                  drain_done_i,
  output logic                  full_o,
  output logic                  inv_o,
  output logic                  user_o,
  output logic                  last_o
);

  bank_state_e state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [BLK_SIZE];
  logic start;

  assign start = wr_en_i && first_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= BANK_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BANK_EMPTY:    if (start) state_nxt = BANK_FILLING;
      BANK_FILLING:  if (wr_en_i && fill_done_i) state_nxt = BANK_FULL;
      BANK_FULL: begin
        if (drain_done_i)    state_nxt = BANK_EMPTY;
        else if (rd_first_i) state_nxt = BANK_DRAINING;
      end
      BANK_DRAINING: if (drain_done_i) state_nxt = BANK_EMPTY;
      default:       state_nxt = BANK_EMPTY;
    endcase
  end

  assign full_o = (state == BANK_FULL) || (state == BANK_DRAINING);

  // Storage is not reset: the state flags alone decide whether it is visible.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_addr_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inv_o  <= 1'b0;
      user_o <= 1'b0;
      last_o <= 1'b0;
    end else if (start) begin
      inv_o  <= inv_i;
      user_o <= user_i;
      last_o <= last_i;
    end else if (wr_en_i) begin
      user_o <= user_o | user_i;
      last_o <= last_o | last_i;
    end
  end

`ifdef ZZ_LAST_NZ_EN
  logic [6:0] zz_pos;
  logic       nz;

  assign zz_pos = {1'b0, zz_idx_i} + 7'd1;
  assign nz     = |wr_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_nz_o <= 7'd0;
    end else if (start) begin
      last_nz_o <= nz ? zz_pos : 7'd0;
    end else if (wr_en_i && nz && (zz_pos > last_nz_o)) begin
      last_nz_o <= zz_pos;
    end
  end
`endif

endmodule

// File: rtl/zig_zag_pp.sv
// zig_zag_pp: ping-pong 8x8 zig-zag reorderer, one coefficient per cycle.
// Forward mode writes in raster order and reads through ZZ2RASTER; inverse
// mode scatters writes through ZZ2RASTER and reads linearly.
// Optional: ZZ_LAST_NZ_EN adds last_nz_o (zig-zag position after the last
// nonzero coefficient of the bank being drained).
//   clk_i, rst_i  clock, async active-high reset
//   inverse_i     1 = zig-zag to raster; sampled on beat 0 of each block
//   dct_i         AXI4-Stream slave, 64 coefficients per block in tdata[DATA_WIDTH-1:0]
//   zz_o          AXI4-Stream master, sign-extended reordered coefficients
//   last_nz_o     (ZZ_LAST_NZ_EN only) last-nonzero count, valid with zz_o.tvalid
module zig_zag_pp
  import zz_pkg::*;
#(
  parameter int DATA_WIDTH = COEF_W,
  parameter int TDATA_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inverse_i,
  axi4_stream_if.slave  dct_i,
  axi4_stream_if.master zz_o
`ifdef ZZ_LAST_NZ_EN
  ,
  output logic [6:0]    last_nz_o
`endif
);

  logic       wr_bank, rd_bank;
  logic [5:0] wr_cnt, rd_cnt;
  logic       wr_acc, rd_hs, wr_first, wr_done, rd_done, wr_inv;
  logic [5:0] wr_addr, rd_addr;
  logic [1:0] full, inv, user, last;
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic signed [DATA_WIDTH-1:0] rd_coef;
`ifdef ZZ_LAST_NZ_EN
  logic [5:0] wr_zz;
  logic [6:0] lnz [2];
`endif

  assign wr_acc   = dct_i.tvalid && dct_i.tready;
  assign rd_hs    = zz_o.tvalid && zz_o.tready;
  assign wr_first = (wr_cnt == 6'd0);
  assign wr_done  = (wr_cnt == 6'(BLK_SIZE - 1));
  assign rd_done  = (rd_cnt == 6'(BLK_SIZE - 1));

  // Beat 0 uses the live mode pin; later beats use the mode latched by the bank.
  assign wr_inv  = wr_first ? inverse_i : inv[wr_bank];
  assign wr_addr = wr_inv ? ZZ2RASTER[wr_cnt] : wr_cnt;
  assign rd_addr = inv[rd_bank] ? rd_cnt : ZZ2RASTER[rd_cnt];
`ifdef ZZ_LAST_NZ_EN
  assign wr_zz   = wr_inv ? wr_cnt : RASTER2ZZ[wr_cnt];
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (wr_acc && (wr_bank == 1'(b))),
      .first_i      (wr_first),
      .fill_done_i  (wr_done),
      .inv_i        (inverse_i),
      .user_i       (dct_i.tuser),
      .last_i       (dct_i.tlast),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (dct_i.tdata[DATA_WIDTH-1:0]),
`ifdef ZZ_LAST_NZ_EN
      .zz_idx_i     (wr_zz),
      .last_nz_o    (lnz[b]),
`endif
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data[b]),
      .rd_first_i   (rd_hs && (rd_bank == 1'(b)) && (rd_cnt == 6'd0)),
      .drain_done_i (rd_hs && (rd_bank == 1'(b)) && rd_done),
      .full_o       (full[b]),
      .inv_o        (inv[b]),
      .user_o       (user[b]),
      .last_o       (last[b])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
    end else begin
      if (wr_acc) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (rd_hs) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  assign dct_i.tready = !rst_i && !full[wr_bank];

  assign rd_coef     = rd_data[rd_bank];
  assign zz_o.tvalid = full[rd_bank];
  assign zz_o.tdata  = zz_o.tvalid ? TDATA_W'(rd_coef) : '0;
  assign zz_o.tuser  = zz_o.tvalid && (rd_cnt == 6'd0) && user[rd_bank];
  assign zz_o.tlast  = zz_o.tvalid && rd_done && last[rd_bank];
  assign zz_o.tstrb  = '1;
  assign zz_o.tkeep  = '1;
`ifdef ZZ_LAST_NZ_EN
  assign last_nz_o   = zz_o.tvalid ? lnz[rd_bank] : 7'd0;
`endif

  logic unused_in;
  assign unused_in = ^{dct_i.tstrb, dct_i.tkeep};

  if (TDATA_W > DATA_WIDTH) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^dct_i.tdata[TDATA_W-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_zig_zag_pp.sv
`timescale 1ns/1ps
module tb_zig_zag_pp;
  localparam int DW = 12;
  localparam int TW = 16;

  typedef int blk_t [64];
  typedef struct {
    logic [TW-1:0] data;
    logic          user;
    logic          last;
    logic [6:0]    lnz;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic inverse_i = 1'b0;
  always #5 clk_i = ~clk_i;

  axi4_stream_if #(.TDATA_W(TW)) dct_if ();
  axi4_stream_if #(.TDATA_W(TW)) zz_if ();
`ifdef ZZ_LAST_NZ_EN
  logic [6:0] last_nz_o;
`endif

  zig_zag_pp #(.DATA_WIDTH(DW), .TDATA_W(TW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inverse_i (inverse_i),
    .dct_i     (dct_if),
    .zz_o      (zz_if)
`ifdef ZZ_LAST_NZ_EN
    ,
    .last_nz_o (last_nz_o)
`endif
  );

  int n_chk = 0, n_err = 0;
  int zz2r [64];
  int r2zz [64];
  exp_t sb [$];
  exp_t mon_e;
  int acc_cnt = 0, out_cnt = 0, rdy_low = 0;
  bit stream_mon = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Zig-zag walk over anti-diagonals: even diagonals climb (row falls), odd descend.
  task automatic build_tables();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz2r[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz2r[k] = r * 8 + (s - r); k++; end
      end
    end
    for (int i = 0; i < 64; i++) r2zz[zz2r[i]] = i;
  endtask

  task automatic push_exp(input blk_t v, input bit inv, input int ub, input int lb);
    exp_t e;
    logic signed [DW-1:0] c;
    int lnz = 0;
    for (int i = 0; i < 64; i++) begin
      c = DW'(v[i]);
      if (c != 0) begin
        int p = (inv ? i : r2zz[i]) + 1;
        if (p > lnz) lnz = p;
      end
    end
    for (int k = 0; k < 64; k++) begin
      c      = DW'(v[inv ? r2zz[k] : zz2r[k]]);
      e.data = TW'(c);
      e.user = (ub >= 0) && (k == 0);
      e.last = (lb >= 0) && (k == 63);
      e.lnz  = 7'(lnz);
      sb.push_back(e);
    end
  endtask

  task automatic send_block(input blk_t v, input bit inv, input int ub, input int lb,
                            input int nbeats, input bit push);
    logic [TW-1:0] d;
    if (push) push_exp(v, inv, ub, lb);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      inverse_i = (i == 0) ? inv : ~inv;
      d = TW'($urandom);
      d[DW-1:0] = DW'(v[i]);
      dct_if.tvalid = 1'b1;
      dct_if.tdata  = d;
      dct_if.tuser  = (i == ub);
      dct_if.tlast  = (i == lb);
      while (!dct_if.tready && n < 500) begin @(posedge clk_i); #1; n++; end
      if (n >= 500) chk("in_tready_timeout", 0, 1);
      @(posedge clk_i); #1;
    end
    dct_if.tvalid = 1'b0;
    dct_if.tuser  = 1'b0;
    dct_if.tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || zz_if.tvalid) && n < 400) begin @(posedge clk_i); #1; n++; end
    chk("drain_timeout", 32'(n < 400), 1);
  endtask

  task automatic rand_blk(output blk_t v);
    for (int i = 0; i < 64; i++)
      v[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 4095)) - 2048;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (dct_if.tvalid && dct_if.tready) acc_cnt++;
      if (stream_mon && !dct_if.tready) rdy_low++;
      if (zz_if.tvalid && zz_if.tready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", zz_if.tdata, mon_e.data);
          chk("out_tuser", zz_if.tuser, mon_e.user);
          chk("out_tlast", zz_if.tlast, mon_e.last);
          chk("out_tkeep", zz_if.tkeep, 2'b11);
`ifdef ZZ_LAST_NZ_EN
          chk("last_nz", last_nz_o, mon_e.lnz);
`endif
        end
      end else if (zz_if.tvalid && sb.size() != 0) begin
        chk("hold_data", zz_if.tdata, sb[0].data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    blk_t v, va, vb, vc;
    int c0, a0;
    build_tables();
    dct_if.tvalid = 1'b0;
    dct_if.tdata  = '0;
    dct_if.tuser  = 1'b0;
    dct_if.tlast  = 1'b0;
    dct_if.tstrb  = '1;
    dct_if.tkeep  = '1;
    zz_if.tready  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tvalid", zz_if.tvalid, 0);
    chk("rst_tdata", zz_if.tdata, 0);
    chk("rst_tuser", zz_if.tuser, 0);
    chk("rst_tlast", zz_if.tlast, 0);
    chk("rst_in_tready", dct_if.tready, 0);
`ifdef ZZ_LAST_NZ_EN
    chk("rst_last_nz", last_nz_o, 0);
`endif
    rst_i = 1'b0;
    #1;
    chk("post_rst_in_tready", dct_if.tready, 1);
    @(posedge clk_i); #1;

    // Forward ramp, tuser on beat 5, tlast on beat 63
    for (int i = 0; i < 64; i++) v[i] = i;
    send_block(v, 0, 5, 63, 64, 1);
    chk("latency_tvalid", zz_if.tvalid, 1);
    chk("latency_first_tuser", zz_if.tuser, 1);
    wait_drain();

    // Inverse: zig-zag sequence in, raster 0..63 out
    for (int i = 0; i < 64; i++) v[i] = zz2r[i];
    send_block(v, 1, -1, -1, 64, 1);
    wait_drain();

    // Streaming, mixed modes, no bubbles
    rand_blk(va); rand_blk(vb); rand_blk(vc);
    rdy_low = 0;
    stream_mon = 1;
    send_block(va, 0, 0, 63, 64, 1);
    c0 = out_cnt;
    chk("stream_latency_tvalid", zz_if.tvalid, 1);
    send_block(vb, 1, 10, -1, 64, 1);
    send_block(vc, 0, -1, 20, 64, 1);
    repeat (64) begin @(posedge clk_i); #1; end
    stream_mon = 0;
    chk("stream_beats", out_cnt - c0, 192);
    chk("stream_in_tready_low", rdy_low, 0);
    chk("stream_end_tvalid", zz_if.tvalid, 0);

    // last_nz corner blocks: raster 0 and 9 nonzero, then all zero
    for (int i = 0; i < 64; i++) v[i] = 0;
    v[0] = 7; v[9] = -3;
    send_block(v, 0, -1, -1, 64, 1);
    v[0] = 0; v[9] = 0;
    send_block(v, 0, -1, -1, 64, 1);
    wait_drain();

    // Backpressure: two banks fill, then input stalls
    zz_if.tready = 1'b0;
    a0 = acc_cnt;
    rand_blk(va); rand_blk(vb); rand_blk(vc);
    send_block(va, 1, -1, 63, 64, 1);
    send_block(vb, 0, 3, -1, 64, 1);
    dct_if.tvalid = 1'b1;
    dct_if.tdata  = TW'(vc[0]);
    repeat (20) begin @(posedge clk_i); #1; end
    chk("bp_accepted", acc_cnt - a0, 128);
    chk("bp_in_tready", dct_if.tready, 0);
    zz_if.tready = 1'b1;
    send_block(vc, 1, -1, -1, 64, 1);
    wait_drain();

    // Reset with one full bank and a partial block
    zz_if.tready = 1'b0;
    rand_blk(va);
    va[0] = 99;
    send_block(va, 0, 0, 63, 64, 0);
    send_block(va, 1, -1, -1, 30, 0);
    chk("pre_rst_tvalid", zz_if.tvalid, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_tvalid", zz_if.tvalid, 0);
    chk("mid_rst_in_tready", dct_if.tready, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    zz_if.tready = 1'b1;
    repeat (5) begin @(posedge clk_i); #1; end
    chk("post_rst_idle_tvalid", zz_if.tvalid, 0);
    rand_blk(vb);
    send_block(vb, 0, 7, 63, 64, 1);
    wait_drain();

    chk("sb_final_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
